// File: rtl/z88_slot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// z88_slot_ctrl_pkg
// Shared definitions for the Z88 unified memory-slot controller:
//   - controller state encoding (IDLE / REQ / HOLD)
//   - fixed channel indices (internal ROM, internal RAM, first card slot)
//   - value returned on the CPU data bus when nothing drives it
//   - width of the access timeout counter
//   - helper sizing the channel-index field for a given channel count
// -----------------------------------------------------------------------------
package z88_slot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } slot_state_e;

    localparam int CH_ROM = 0;
    localparam int CH_RAM = 1;
    localparam int CH_SE1 = 2;

    localparam logic [7:0] FLOAT_DATA = 8'hFF;

    localparam int TO_CNT_W = 8;

    // Width of a channel index; a single-channel build still needs one bit.
    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/z88_slot_sel.sv
// -----------------------------------------------------------------------------
// z88_slot_sel
// Combinational channel selector. Picks the lowest-numbered active (low)
// chip select, flags when more than one select is low, and forms the
// external address as CH_BASE[ch] | (ma & CH_MASK[ch]).
//
// Ports:
//   cs_n      in   NCH     channel selects, active low
//   ma        in   MA_W    Blink memory address
//   ch_idx    out  CH_W    index of the winning channel (0 when none)
//   mem_a     out  MEM_AW  relocated external address for that channel
//   any_sel   out  1       at least one select is low
//   multi_hit out  1       more than one select is low
// -----------------------------------------------------------------------------
module z88_slot_sel
    import z88_slot_ctrl_pkg::*;
#(
    parameter  int                      NCH     = 5,
    parameter  int                      MA_W    = 22,
    parameter  int                      MEM_AW  = 24,
    parameter  logic [NCH*MEM_AW-1:0]   CH_BASE = '0,
    parameter  logic [NCH*MEM_AW-1:0]   CH_MASK = {NCH{MEM_AW'(24'h07FFFF)}},
    localparam int                      CH_W    = ch_idx_w(NCH)
) (
    input  logic [NCH-1:0]    cs_n,
    input  logic [MA_W-1:0]   ma,
    output logic [CH_W-1:0]   ch_idx,
    output logic [MEM_AW-1:0] mem_a,
    output logic              any_sel,
    output logic              multi_hit
);

    logic [MEM_AW-1:0] ma_ext;
    logic [MEM_AW-1:0] base;
    logic [MEM_AW-1:0] mask;

    // Fit the Blink address to the external address width.
    if (MA_W >= MEM_AW) begin : g_ma_trunc
        assign ma_ext = ma[MEM_AW-1:0];
    end else begin : g_ma_zext
        assign ma_ext = {{(MEM_AW-MA_W){1'b0}}, ma};
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves one unassigned infers a latch.
        ch_idx    = '0;
        base      = '0;
        mask      = '0;
        any_sel   = 1'b0;
        multi_hit = 1'b0;
        // Scan from the top down so the lowest active index is written last
        // and therefore wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!cs_n[i]) begin
                if (any_sel) begin
                    multi_hit = 1'b1;
                end
                any_sel = 1'b1;
                ch_idx  = CH_W'(i);
                base    = CH_BASE[i*MEM_AW +: MEM_AW];
                mask    = CH_MASK[i*MEM_AW +: MEM_AW];
            end
        end
        mem_a = base | (ma_ext & mask);
    end

endmodule

// File: rtl/z88_slot_ctrl.sv
// -----------------------------------------------------------------------------
// z88_slot_ctrl
// Unified Z88 memory-channel controller. Turns Blink chip selects and
// read/write strobes into a single req/ack transaction on the board memory
// port, stalls the Z80 through cpu_wait_n while the transaction is open,
// relocates each channel into external memory, blocks writes to protected
// channels, aborts requests that are never acknowledged, and returns read
// data from a register.
//
// Optional feature: define Z88_SLOT_CARD_WP_EN to add the card_wp input;
// a write to channel k with card_wp[k]=1 is treated like a ROM write.
// Without it only channel 0 (ROM) is write protected.
//
// Ports:
//   clk         in   1       master clock
//   reset_n     in   1       synchronous reset, active low
//   cs_n        in   NCH     channel selects (0=ROM, 1=RAM, 2..=card slots)
//   roe_n       in   1       read strobe, active low
//   wrb_n       in   1       write strobe, active low
//   ma          in   MA_W    Blink memory address
//   cpu_wdata   in   8       Z80 write data
//   card_wp     in   NCH     per-channel write protect (optional)
//   cpu_rdata   out  8       registered read data to Blink
//   cpu_wait_n  out  1       low stalls the Z80
//   mem_req     out  1       external request, held until mem_ack
//   mem_we      out  1       external write enable
//   mem_a       out  MEM_AW  external address
//   mem_wdata   out  8       external write data
//   mem_rdata   in   8       external read data, valid with mem_ack
//   mem_ack     in   1       one-cycle completion pulse
//   wp_err      out  1       pulse: write to a protected channel
//   to_err      out  1       pulse: request aborted by timeout
//   ch_err      out  1       pulse: several selects low at capture
// -----------------------------------------------------------------------------
module z88_slot_ctrl
    import z88_slot_ctrl_pkg::*;
#(
    parameter int                    NCH     = 5,
    parameter int                    MA_W    = 22,
    parameter int                    MEM_AW  = 24,
    parameter logic [NCH*MEM_AW-1:0] CH_BASE = '0,
    parameter logic [NCH*MEM_AW-1:0] CH_MASK = {NCH{MEM_AW'(24'h07FFFF)}},
    parameter int                    TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    cs_n,
    input  logic              roe_n,
    input  logic              wrb_n,
    input  logic [MA_W-1:0]   ma,
    input  logic [7:0]        cpu_wdata,
`ifdef Z88_SLOT_CARD_WP_EN
    input  logic [NCH-1:0]    card_wp,
`endif
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_a,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              wp_err,
    output logic              to_err,
    output logic              ch_err
);

    localparam int                  CH_W    = ch_idx_w(NCH);
    // Abort happens on the TIMEOUT-th unacknowledged REQ cycle; the counter
    // starts at zero on entry, so that is the cycle it holds TIMEOUT-1.
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    slot_state_e         state_q,     state_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [MEM_AW-1:0]   mem_a_q,     mem_a_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic [TO_CNT_W-1:0] to_cnt_q,    to_cnt_d;
    logic                wp_err_q,    wp_err_d;
    logic                to_err_q,    to_err_d;
    logic                ch_err_q,    ch_err_d;

    logic [CH_W-1:0]     sel_ch;
    logic [MEM_AW-1:0]   sel_a;
    logic                sel_any;
    logic                sel_multi;
    logic                access;
    logic                is_write;
    logic                wp_hit;

    z88_slot_sel #(
        .NCH     (NCH),
        .MA_W    (MA_W),
        .MEM_AW  (MEM_AW),
        .CH_BASE (CH_BASE),
        .CH_MASK (CH_MASK)
    ) u_sel (
        .cs_n      (cs_n),
        .ma        (ma),
        .ch_idx    (sel_ch),
        .mem_a     (sel_a),
        .any_sel   (sel_any),
        .multi_hit (sel_multi)
    );

    assign access   = sel_any & (~roe_n | ~wrb_n);
    // Write wins when both strobes are low.
    assign is_write = ~wrb_n;

`ifdef Z88_SLOT_CARD_WP_EN
    assign wp_hit = (sel_ch == CH_W'(CH_ROM)) | card_wp[sel_ch];
`else
    assign wp_hit = (sel_ch == CH_W'(CH_ROM));
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_a_d     = mem_a_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        to_cnt_d    = to_cnt_q;
        wp_err_d    = 1'b0;
        to_err_d    = 1'b0;
        ch_err_d    = 1'b0;
        cpu_wait_n  = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    // Stall immediately, before the request is even issued.
                    cpu_wait_n  = 1'b0;
                    mem_a_d     = sel_a;
                    mem_we_d    = is_write;
                    mem_wdata_d = cpu_wdata;
                    ch_err_d    = sel_multi;
                    if (is_write && wp_hit) begin
                        // Blocked write: never reaches the memory port.
                        wp_err_d = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        mem_req_d = 1'b1;
                        to_cnt_d  = '0;
                        state_d   = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                cpu_wait_n = 1'b0;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = ST_HOLD;
                end else if (to_cnt_q == TO_LAST) begin
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = FLOAT_DATA;
                    to_err_d    = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                end
            end

            ST_HOLD: begin
                // Wait for the CPU cycle to end so one strobe is served once.
                if (!access) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples its _d value from before this edge.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= FLOAT_DATA;
            to_cnt_q    <= '0;
            wp_err_q    <= 1'b0;
            to_err_q    <= 1'b0;
            ch_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            to_cnt_q    <= to_cnt_d;
            wp_err_q    <= wp_err_d;
            to_err_q    <= to_err_d;
            ch_err_q    <= ch_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_a     = mem_a_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign wp_err    = wp_err_q;
    assign to_err    = to_err_q;
    assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_z88_slot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z88_slot_ctrl
// Self-checking bench for z88_slot_ctrl. The bench plays both Blink and the
// board memory. A transaction-level reference model tracks what the
// controller owes the CPU (free / waiting on memory / served, waiting for
// release) and a single compare process checks every output each cycle.
// Directed scenarios add literal expectations; a randomized loop follows.
// -----------------------------------------------------------------------------
module tb_z88_slot_ctrl;
    import z88_slot_ctrl_pkg::*;

    localparam int NCH = 5;
    localparam int TMO = 255;

    localparam logic [NCH*24-1:0] TB_BASE =
        {24'h400000, 24'h200000, 24'h300000, 24'h080000, 24'h000000};
    localparam logic [NCH*24-1:0] TB_MASK =
        {24'h03FFFF, 24'h0FFFFF, 24'h07FFFF, 24'h07FFFF, 24'h07FFFF};

    // Model copies of the channel map, written independently of the packing.
    logic [23:0] m_base [NCH] = '{24'h000000, 24'h080000, 24'h300000, 24'h200000, 24'h400000};
    logic [23:0] m_mask [NCH] = '{24'h07FFFF, 24'h07FFFF, 24'h07FFFF, 24'h0FFFFF, 24'h03FFFF};

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] cs_n;
    logic           roe_n;
    logic           wrb_n;
    logic [21:0]    ma;
    logic [7:0]     cpu_wdata;
    logic [7:0]     cpu_rdata;
    logic           cpu_wait_n;
    logic           mem_req;
    logic           mem_we;
    logic [23:0]    mem_a;
    logic [7:0]     mem_wdata;
    logic [7:0]     mem_rdata;
    logic           mem_ack;
    logic           wp_err;
    logic           to_err;
    logic           ch_err;
`ifdef Z88_SLOT_CARD_WP_EN
    logic [NCH-1:0] card_wp = 5'b00100;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    z88_slot_ctrl #(
        .NCH     (NCH),
        .MA_W    (22),
        .MEM_AW  (24),
        .CH_BASE (TB_BASE),
        .CH_MASK (TB_MASK),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs_n       (cs_n),
        .roe_n      (roe_n),
        .wrb_n      (wrb_n),
        .ma         (ma),
        .cpu_wdata  (cpu_wdata),
`ifdef Z88_SLOT_CARD_WP_EN
        .card_wp    (card_wp),
`endif
        .cpu_rdata  (cpu_rdata),
        .cpu_wait_n (cpu_wait_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .wp_err     (wp_err),
        .to_err     (to_err),
        .ch_err     (ch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    localparam int M_FREE    = 0;  // nothing owed to the CPU
    localparam int M_WAITMEM = 1;  // request outstanding on the memory port
    localparam int M_DONE    = 2;  // served; waiting for the CPU to let go

    int          m_phase = M_FREE;
    int          m_wait  = 0;
    bit          m_valid = 1'b0;
    logic        e_req, e_we, e_wp, e_to, e_ch;
    logic [23:0] e_a;
    logic [7:0]  e_wd, e_rd;

    // Inputs change just after posedge, so at negedge they are exactly what
    // the next edge will sample, and registered outputs reflect the last one.
    always @(negedge clk) begin : compare
        logic acc;
        logic exp_wait;
        logic prot;
        int   ch;
        int   nsel;
        acc = (cs_n != 5'h1F) && (!roe_n || !wrb_n);
        if (m_valid) begin
            exp_wait = !((m_phase == M_WAITMEM) || (m_phase == M_FREE && acc));
            check("cpu_wait_n", 32'(cpu_wait_n), 32'(exp_wait));
            check("mem_req",    32'(mem_req),    32'(e_req));
            check("mem_we",     32'(mem_we),     32'(e_we));
            check("mem_a",      32'(mem_a),      32'(e_a));
            check("mem_wdata",  32'(mem_wdata),  32'(e_wd));
            check("cpu_rdata",  32'(cpu_rdata),  32'(e_rd));
            check("wp_err",     32'(wp_err),     32'(e_wp));
            check("to_err",     32'(to_err),     32'(e_to));
            check("ch_err",     32'(ch_err),     32'(e_ch));
        end
        e_wp = 1'b0;
        e_to = 1'b0;
        e_ch = 1'b0;
        if (!reset_n) begin
            m_phase = M_FREE;
            m_wait  = 0;
            e_req   = 1'b0;
            e_we    = 1'b0;
            e_a     = 24'h0;
            e_wd    = 8'h00;
            e_rd    = 8'hFF;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                M_FREE: if (acc) begin
                    ch   = -1;
                    nsel = 0;
                    for (int i = 0; i < NCH; i++) begin
                        if (!cs_n[i]) begin
                            nsel++;
                            if (ch < 0) ch = i;
                        end
                    end
                    e_a  = m_base[ch] | ({2'b00, ma} & m_mask[ch]);
                    e_we = !wrb_n;
                    e_wd = cpu_wdata;
                    e_ch = (nsel > 1);
                    prot = (ch == 0);
`ifdef Z88_SLOT_CARD_WP_EN
                    prot = prot || card_wp[ch];
`endif
                    if (e_we && prot) begin
                        e_wp    = 1'b1;
                        m_phase = M_DONE;
                    end else begin
                        e_req   = 1'b1;
                        m_wait  = 0;
                        m_phase = M_WAITMEM;
                    end
                end
                M_WAITMEM: begin
                    if (mem_ack) begin
                        e_req = 1'b0;
                        if (!e_we) e_rd = mem_rdata;
                        m_phase = M_DONE;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin
                            e_req   = 1'b0;
                            e_rd    = 8'hFF;
                            e_to    = 1'b1;
                            m_phase = M_DONE;
                        end
                    end
                end
                default: if (!acc) m_phase = M_FREE;
            endcase
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        cs_n    = 5'h1F;
        roe_n   = 1'b1;
        wrb_n   = 1'b1;
        mem_ack = 1'b0;
        step();
        step();
    endtask

    // kind: 0 = read, 1 = write, 2 = both strobes. ack_dly: number of
    // mem_req-high cycles before ack is presented (0 = never ack).
    task automatic do_access(input logic [4:0] cs, input int kind, input logic [21:0] a,
                             input logic [7:0] d, input int ack_dly, input logic [7:0] rd,
                             input int hold, input bit jitter,
                             output int low_c, output int req_c, output int wp_n,
                             output int to_n, output int ch_n, output int extra);
        int cyc;
        bit done;
        cs_n      = cs;
        ma        = a;
        cpu_wdata = d;
        roe_n     = (kind == 1);
        wrb_n     = (kind == 0);
        mem_ack   = 1'b0;
        #1;
        low_c = 0; req_c = 0; wp_n = 0; to_n = 0; ch_n = 0; extra = 0;
        cyc = 0;
        done = 1'b0;
        while (!done) begin
            if (!cpu_wait_n) low_c++;
            step();
            cyc++;
            mem_ack = 1'b0;
            if (jitter) mem_rdata = 8'($urandom);
            wp_n += int'(wp_err);
            to_n += int'(to_err);
            ch_n += int'(ch_err);
            if (mem_req) begin
                req_c++;
                if (req_c == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end else if (jitter && $urandom_range(3) == 0) begin
                    ma        = 22'($urandom);
                    cpu_wdata = 8'($urandom);
                end
            end
            if (cpu_wait_n && !mem_req) done = 1'b1;
            if (cyc > 600) begin
                n_checks++;
                n_fail++;
                $display("FAIL access_bound: no completion after %0d cycles", cyc);
                done = 1'b1;
            end
        end
        for (int i = 0; i < hold; i++) begin
            if (jitter) begin
                mem_ack   = 1'($urandom_range(1));
                mem_rdata = 8'($urandom);
            end
            step();
            extra += int'(mem_req);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, rq, wp, tn, cn, ex;
        reset_n   = 1'b0;
        cs_n      = 5'h1F;
        roe_n     = 1'b1;
        wrb_n     = 1'b1;
        ma        = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;

        // Reset state.
        check("rst_mem_req",    32'(mem_req),    32'h0);
        check("rst_cpu_rdata",  32'(cpu_rdata),  32'hFF);
        check("rst_wait_n",     32'(cpu_wait_n), 32'h1);
        check("rst_mem_a",      32'(mem_a),      32'h0);
        check("rst_errs",       32'({wp_err, to_err, ch_err}), 32'h0);

        // RAM read, ack on the third request cycle.
        do_access(~(5'b1 << CH_RAM), 0, 22'h000123, 8'h00, 3, 8'h5A, 0, 1'b0,
                  lo, rq, wp, tn, cn, ex);
        check("ram_rd_mem_a",   32'(mem_a),      32'h080123);
        check("ram_rd_we",      32'(mem_we),     32'h0);
        check("ram_rd_wait_lo", 32'(lo),         32'd4);
        check("ram_rd_req_cyc", 32'(rq),         32'd3);
        check("ram_rd_data",    32'(cpu_rdata),  32'h5A);
        check("ram_rd_wait_hi", 32'(cpu_wait_n), 32'h1);
        release_bus();

        // ROM write is blocked.
        do_access(5'b11110, 1, 22'h000010, 8'h99, 1, 8'h00, 0, 1'b0, lo, rq, wp, tn, cn, ex);
        check("rom_wr_req_cyc", 32'(rq), 32'd0);
        check("rom_wr_wp",      32'(wp), 32'd1);
        check("rom_wr_wait_lo", 32'(lo), 32'd1);
        release_bus();

        // Card-slot write with relocation.
        do_access(~(5'b1 << (CH_SE1 + 1)), 1, 22'h3FFFFF, 8'hC3, 2, 8'h00, 0, 1'b0,
                  lo, rq, wp, tn, cn, ex);
        check("card_wr_mem_a",  32'(mem_a),     32'h2FFFFF);
        check("card_wr_we",     32'(mem_we),    32'h1);
        check("card_wr_wdata",  32'(mem_wdata), 32'hC3);
        check("card_wr_rdata",  32'(cpu_rdata), 32'h5A);
        release_bus();

        // Multiple selects: ch0 wins, one request despite a long strobe.
        do_access(5'b11100, 0, 22'h012345, 8'h00, 2, 8'h3C, 10, 1'b0, lo, rq, wp, tn, cn, ex);
        check("multi_ch_err",   32'(cn),        32'd1);
        check("multi_mem_a",    32'(mem_a),     32'h012345);
        check("multi_data",     32'(cpu_rdata), 32'h3C);
        check("multi_extra_rq", 32'(ex),        32'd0);
        check("multi_req_cyc",  32'(rq),        32'd2);
        release_bus();

        // Reset in the middle of a request.
        cs_n  = ~(5'b1 << CH_RAM);
        roe_n = 1'b0;
        ma    = 22'h000456;
        #1;
        repeat (3) step();
        check("rstmid_req_on",  32'(mem_req), 32'h1);
        reset_n = 1'b0;
        cs_n    = 5'h1F;
        roe_n   = 1'b1;
        step();
        reset_n = 1'b1;
        check("rstmid_req",     32'(mem_req),    32'h0);
        check("rstmid_rdata",   32'(cpu_rdata),  32'hFF);
        check("rstmid_wait_n",  32'(cpu_wait_n), 32'h1);
        step();

        // Refill read data, then a read that never gets acknowledged.
        do_access(~(5'b1 << CH_RAM), 0, 22'h000777, 8'h00, 1, 8'h77, 0, 1'b0,
                  lo, rq, wp, tn, cn, ex);
        check("refill_data",    32'(cpu_rdata), 32'h77);
        release_bus();
        do_access(~(5'b1 << CH_RAM), 0, 22'h000100, 8'h00, 0, 8'h00, 3, 1'b0,
                  lo, rq, wp, tn, cn, ex);
        check("tmo_to_err",     32'(tn),         32'd1);
        check("tmo_req_cyc",    32'(rq),         32'd255);
        check("tmo_rdata",      32'(cpu_rdata),  32'hFF);
        check("tmo_hold_wait",  32'(cpu_wait_n), 32'h1);
        check("tmo_extra_rq",   32'(ex),         32'd0);
        release_bus();

`ifdef Z88_SLOT_CARD_WP_EN
        do_access(~(5'b1 << CH_SE1), 1, 22'h000055, 8'hAA, 1, 8'h00, 0, 1'b0,
                  lo, rq, wp, tn, cn, ex);
        check("cardwp_wp",      32'(wp), 32'd1);
        check("cardwp_req_cyc", 32'(rq), 32'd0);
        release_bus();
`endif

        // Randomized traffic; the compare process judges every cycle.
        for (int t = 0; t < 200; t++) begin
            logic [4:0] cs;
            if ($urandom_range(4) == 0) begin
                cs = 5'($urandom);
                if (cs == 5'h1F) cs = 5'h0E;
            end else begin
                cs = ~(5'b1 << $urandom_range(NCH - 1));
            end
            do_access(cs, int'($urandom_range(2)), 22'($urandom), 8'($urandom),
                      int'($urandom_range(6, 1)), 8'($urandom), int'($urandom_range(3)),
                      1'b1, lo, rq, wp, tn, cn, ex);
            cs_n    = 5'h1F;
            roe_n   = 1'b1;
            wrb_n   = 1'b1;
            mem_ack = 1'($urandom_range(1));
            step();
            mem_ack = 1'b0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/z88_slot_ctrl.md
Name: z88_slot_ctrl

Overview:
- Parametrised successor to the fixed slot-0 ROM/RAM glue: one controller serves every Z88 memory channel (internal ROM, internal RAM, card slots 1..N) from a single unified external memory port.
- Converts Blink chip-selects/strobes into a req/ack transaction; stalls the CPU via `cpu_wait_n` until complete.
- Adds per-channel address relocation, write protection, access timeout and a registered read-data return.
- Sits between Blink (`ma`/selects/strobes) and the board memory controller; replaces the combinational `cdi` read mux.

Parameters:
- NCH, 5, channel count: ch0 = ROM (`ipce_n`), ch1 = RAM (`irce_n`), ch2..NCH-1 = card slots (`se1_n`..).
- MA_W, 22, Blink address width.
- MEM_AW, 24, external memory address width.
- CH_BASE, {NCH{24'h0}} flattened, per-channel base address in external memory (MEM_AW bits each).
- CH_MASK, {NCH{24'h07FFFF}} flattened, per-channel offset mask applied to `ma`.
- TIMEOUT, 255, cycles without `mem_ack` before abort; 8-bit counter.

Ports:
- clk  in  1  master clock (mck domain)
- reset_n  in  1  synchronous active-low reset
- cs_n  in  NCH  channel selects, bit0 = ipce_n, bit1 = irce_n, bit k = se(k-1)_n
- roe_n  in  1  read strobe, active low
- wrb_n  in  1  write strobe, active low
- ma  in  MA_W  Blink memory address
- cpu_wdata  in  8  Z80 write data
- cpu_rdata  out  8  read data to Blink `cdi`
- cpu_wait_n  out  1  low = stall Z80 clock enable
- mem_req  out  1  external request, held until `mem_ack`
- mem_we  out  1  1 = write
- mem_a  out  MEM_AW  external address
- mem_wdata  out  8  external write data
- mem_rdata  in  8  external read data, valid with `mem_ack`
- mem_ack  in  1  one-cycle completion pulse
- wp_err  out  1  one-cycle pulse: write to protected channel
- to_err  out  1  one-cycle pulse: timeout abort
- ch_err  out  1  one-cycle pulse: more than one `cs_n` low at capture

Behaviour:
- Access = any `cs_n` low AND (`roe_n` low OR `wrb_n` low), sampled each clk.
- Reset: state IDLE; `mem_req`=0, `mem_we`=0, `mem_a`=0, `mem_wdata`=0, `cpu_rdata`=8'hFF, `cpu_wait_n`=1, all err=0, timeout counter=0.
- State machine:
  - IDLE: on access, capture channel (lowest index low wins; `ch_err` pulses if >1 low), `mem_a` = CH_BASE[ch] | (ma & CH_MASK[ch]), `mem_we` = ~`wrb_n` (write wins if both strobes low), `mem_wdata` = `cpu_wdata`; go REQ.
  - Protected write in IDLE (ch0 always): no `mem_req`; pulse `wp_err`; go HOLD.
  - REQ: `mem_req`=1; counter increments. On `mem_ack`: `mem_req`=0; on read latch `cpu_rdata` = `mem_rdata`; go HOLD. Counter reaching TIMEOUT with no ack: `mem_req`=0, `cpu_rdata`=8'hFF, pulse `to_err`, go HOLD.
  - HOLD: wait for the access to drop (strobes or selects high), then IDLE. No re-trigger while the same strobe stays low.
- `cpu_wait_n`: combinationally 0 when access present in IDLE, and throughout REQ; 1 in HOLD/IDLE-no-access.
- Latency: `mem_req` rises 1 clk after access sampled. `cpu_rdata` valid and `cpu_wait_n` high the clk after `mem_ack`.
- `cpu_rdata` holds its last value in IDLE. Counter clears on entry to REQ.
- `mem_ack` outside REQ: ignored.
- Address/strobe changes during REQ: ignored; captured values are used.
- Reset mid-transaction: immediate return to IDLE with `mem_req`=0. External memory tolerates an abandoned request.

Optional Feature:
- Macro: Z88_SLOT_CARD_WP_EN.
- Defined: adds input port `card_wp` [NCH-1:0]. A write to ch k with `card_wp[k]`=1 takes the protected-write path.
- Undefined: port absent; only ch0 is protected.

Decomposition:
- Shared header `z88_slot_defs.vh`:
  - state encodings (IDLE=2'd0, REQ=2'd1, HOLD=2'd2)
  - channel indices CH_ROM=0, CH_RAM=1, CH_SE1=2
  - default 8'hFF float value
- One sub-module, `z88_slot_sel`: combinational priority encoder plus base/mask address computation. Outputs ch index, `mem_a`, multi-hit flag.

Test Plan:
- RAM read: `cs_n`[1]=0, `roe_n`=0, ma=22'h000123, CH_BASE[1]=24'h080000, ack after 3 clk with 8'h5A -> `mem_a`=24'h080123, `mem_we`=0, `cpu_wait_n` low 4 clk, `cpu_rdata`=8'h5A.
- ROM write: `cs_n`[0]=0, `wrb_n`=0 -> no `mem_req`, `wp_err` one pulse, `cpu_wait_n` low 1 clk only.
- Card-slot write: `cs_n`[3]=0, `wrb_n`=0, ma=22'h3FFFFF, mask 24'h0FFFFF, base 24'h200000, data 8'hC3 -> `mem_a`=24'h2FFFFF, `mem_we`=1, `mem_wdata`=8'hC3.
- No ack within 255 clk on a read -> `to_err` pulse, `cpu_rdata`=8'hFF, state HOLD, then IDLE after strobe released.
- `cs_n`=5'b11100 with read -> ch0 served, `ch_err` pulses. Strobe held 10 clk after ack -> exactly one `mem_req`.
- `reset_n` low 1 clk during REQ -> next clk `mem_req`=0, `cpu_rdata`=8'hFF, IDLE. With Z88_SLOT_CARD_WP_EN and `card_wp`[2]=1: write to ch2 -> `wp_err`, no `mem_req`.
